// File: rtl/edge_track_multi_if.sv
// Channel bus for edge_track_multi: raw levels and enables in, run/last status and run lengths out.
interface edge_track_multi_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
);
  logic [NCH-1:0]       do_i;
  logic [NCH-1:0]       en_i;
  logic [NCH-1:0]       r_o;
  logic [NCH-1:0]       f_o;
  logic [NCH*CNT_W-1:0] len_o;
  logic [NCH-1:0]       len_vld_o;
  logic                 busy_o;

  modport master (output do_i, en_i, input r_o, f_o, len_o, len_vld_o, busy_o);
  modport slave  (input do_i, en_i, output r_o, f_o, len_o, len_vld_o, busy_o);
endinterface

// File: rtl/edge_track_multi.sv
// Multi-channel debounced level tracker: IDLE/RUN/LAST FSM per channel with run-length capture.
module edge_track_multi #(
  parameter int NCH      = 4,
  parameter int FILT     = 2,
  parameter int LAST_LEN = 1,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  edge_track_multi_if.slave bus
);
  localparam logic [1:0]       S_IDLE = 2'd0;
  localparam logic [1:0]       S_RUN  = 2'd1;
  localparam logic [1:0]       S_LAST = 2'd2;
  localparam logic [3:0]       MC_END = 4'(FILT - 1);
  localparam logic [7:0]       LC_END = 8'(LAST_LEN - 1);
  localparam logic [CNT_W-1:0] RC_MAX = '1;

  logic [NCH-1:0]            r_nxt, r_all, f_all, vld_all;
  logic [NCH-1:0][CNT_W-1:0] len_all;
  logic                      busy_q;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic             din, en;
    logic [1:0]       st_q, st_d;
    logic             flt_q, flt_d;
    logic [3:0]       mc_q, mc_d;
    logic [CNT_W-1:0] rc_q, rc_d, len_q, len_d;
    logic [7:0]       lc_q, lc_d;
    logic             r_q, r_d, f_q, f_d, vld_q, vld_d;

    assign din = bus.do_i[g];
    assign en  = bus.en_i[g];

    // Debounce: a new level must persist for FILT consecutive samples.
    always_comb begin
      flt_d = flt_q;
      mc_d  = '0;
      if (din != flt_q) begin
        if (mc_q == MC_END) flt_d = din;
        else                mc_d  = mc_q + 4'd1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st_q <= S_IDLE;
      else        st_q <= st_d;
    end

    always_comb begin
      st_d = S_IDLE;
      if (en) begin
        case (st_q)
          S_IDLE:  st_d = flt_q ? S_RUN : S_IDLE;
          S_RUN:   st_d = flt_q ? S_RUN : S_LAST;
          S_LAST: begin
            if (flt_q)               st_d = S_RUN;
            else if (lc_q == LC_END) st_d = S_IDLE;
            else                     st_d = S_LAST;
          end
          default: st_d = S_IDLE;
        endcase
      end
    end

    // Outputs are registered from next-state so they move with the state register.
    always_comb begin
      r_d   = (st_d == S_RUN);
      f_d   = (st_d == S_LAST);
      vld_d = (st_q == S_RUN) && (st_d == S_LAST);
      len_d = vld_d ? rc_q : len_q;
      rc_d  = rc_q;
      if (st_d == S_RUN) begin
        if (st_q != S_RUN)      rc_d = {{(CNT_W-1){1'b0}}, 1'b1};
        else if (rc_q != RC_MAX) rc_d = rc_q + 1'b1;
      end
      lc_d = ((st_q == S_LAST) && (st_d == S_LAST)) ? lc_q + 8'd1 : 8'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        flt_q <= 1'b0;
        mc_q  <= '0;
        rc_q  <= '0;
        lc_q  <= '0;
        len_q <= '0;
        r_q   <= 1'b0;
        f_q   <= 1'b0;
        vld_q <= 1'b0;
      end else begin
        flt_q <= flt_d;
        mc_q  <= mc_d;
        rc_q  <= rc_d;
        lc_q  <= lc_d;
        len_q <= len_d;
        r_q   <= r_d;
        f_q   <= f_d;
        vld_q <= vld_d;
      end
    end

    assign r_nxt[g]   = r_d;
    assign r_all[g]   = r_q;
    assign f_all[g]   = f_q;
    assign vld_all[g] = vld_q;
    assign len_all[g] = len_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= 1'b0;
    else        busy_q <= |r_nxt;
  end

  assign bus.r_o       = r_all;
  assign bus.f_o       = f_all;
  assign bus.len_vld_o = vld_all;
  assign bus.len_o     = len_all;
  assign bus.busy_o    = busy_q;
endmodule

// File: tb/tb_edge_track_multi.sv
// Directed bench: default, CNT_W=4 and LAST_LEN=4 instances driven by one linear sequence.
module tb_edge_track_multi;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  edge_track_multi_if #(.NCH(4), .CNT_W(8)) if0 ();
  edge_track_multi_if #(.NCH(4), .CNT_W(4)) if1 ();
  edge_track_multi_if #(.NCH(4), .CNT_W(8)) if2 ();

  edge_track_multi #(.NCH(4), .FILT(2), .LAST_LEN(1), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  edge_track_multi #(.NCH(4), .FILT(2), .LAST_LEN(1), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));
  edge_track_multi #(.NCH(4), .FILT(2), .LAST_LEN(4), .CNT_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(if2.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int npulse;
    if0.do_i = '0; if0.en_i = '0;
    if1.do_i = '0; if1.en_i = '0;
    if2.do_i = '0; if2.en_i = '0;

    // reset state
    tick(); tick(); tick();
    chk("rst_r",    32'(if0.r_o),       32'd0);
    chk("rst_f",    32'(if0.f_o),       32'd0);
    chk("rst_len",  32'(if0.len_o),     32'd0);
    chk("rst_vld",  32'(if0.len_vld_o), 32'd0);
    chk("rst_busy", 32'(if0.busy_o),    32'd0);
    rst_n = 1'b1;
    if0.en_i = 4'hF; if1.en_i = 4'hF; if2.en_i = 4'hF;

    // ch0 high for samples E0..E9
    if0.do_i[0] = 1'b1;
    for (int e = 0; e <= 14; e++) begin
      tick();
      chk("t032_r",    32'(if0.r_o[0]),       32'(e >= 2 && e <= 11));
      chk("t032_f",    32'(if0.f_o[0]),       32'(e == 12));
      chk("t032_vld",  32'(if0.len_vld_o[0]), 32'(e == 12));
      chk("t032_busy", 32'(if0.busy_o),       32'(e >= 2 && e <= 11));
      if (e == 11) chk("t032_len_pre", 32'(if0.len_o[7:0]), 32'd0);
      if (e == 12) chk("t032_len",     32'(if0.len_o[7:0]), 32'd10);
      if (e == 9) if0.do_i[0] = 1'b0;
    end

    // single-sample glitch on ch1 is filtered out
    if0.do_i[1] = 1'b1;
    tick();
    if0.do_i[1] = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk("t033_r",   32'(if0.r_o[1]),       32'd0);
      chk("t033_f",   32'(if0.f_o[1]),       32'd0);
      chk("t033_vld", 32'(if0.len_vld_o[1]), 32'd0);
    end

    // en[0] dropped mid-run while ch1 keeps running
    if0.do_i[1:0] = 2'b11;
    for (int e = 0; e <= 3; e++) tick();
    chk("t036_r_both", 32'(if0.r_o[1:0]), 32'd3);
    if0.en_i[0] = 1'b0;
    tick();
    chk("t036_r0_off", 32'(if0.r_o[0]),       32'd0);
    chk("t036_f0",     32'(if0.f_o[0]),       32'd0);
    chk("t036_vld0",   32'(if0.len_vld_o[0]), 32'd0);
    chk("t036_r1_on",  32'(if0.r_o[1]),       32'd1);
    tick(); tick();
    chk("t036_vld0_b", 32'(if0.len_vld_o[0]), 32'd0);
    chk("t036_r1_b",   32'(if0.r_o[1]),       32'd1);
    if0.do_i[1] = 1'b0;
    tick(); tick();
    chk("t036_r1_c",   32'(if0.r_o[1]), 32'd1);
    tick();
    chk("t036_f1",     32'(if0.f_o[1]),         32'd1);
    chk("t036_vld1",   32'(if0.len_vld_o[1]),   32'd1);
    chk("t036_len1",   32'(if0.len_o[15:8]),    32'd7);
    chk("t036_len0",   32'(if0.len_o[7:0]),     32'd10);
    if0.do_i[0] = 1'b0;
    tick(); tick(); tick();
    if0.en_i[0] = 1'b1;
    tick();
    chk("t036_idle0", 32'(if0.r_o[0]), 32'd0);

    // saturating run counter, CNT_W=4, ch2 high for 20 cycles
    npulse = 0;
    if1.do_i[2] = 1'b1;
    for (int e = 0; e <= 25; e++) begin
      tick();
      if (if1.len_vld_o[2]) npulse++;
      if (e == 21) chk("t034_r",  32'(if1.r_o[2]), 32'd1);
      if (e == 22) chk("t034_f",  32'(if1.f_o[2]), 32'd1);
      if (e == 22) chk("t034_len", 32'(if1.len_o[11:8]), 32'd15);
      if (e == 19) if1.do_i[2] = 1'b0;
    end
    chk("t034_npulse", 32'(npulse), 32'd1);

    // retrigger out of LAST, LAST_LEN=4, ch3
    if2.do_i[3] = 1'b1;
    for (int e = 0; e <= 14; e++) begin
      tick();
      chk("t035_r",   32'(if2.r_o[3]),       32'((e >= 2 && e <= 7) || e >= 10));
      chk("t035_f",   32'(if2.f_o[3]),       32'(e == 8 || e == 9));
      chk("t035_vld", 32'(if2.len_vld_o[3]), 32'(e == 8));
      if (e == 5) if2.do_i[3] = 1'b0;
      if (e == 7) if2.do_i[3] = 1'b1;
    end
    chk("t035_len", 32'(if2.len_o[31:24]), 32'd6);

    // asynchronous reset while ch0 is running
    if0.do_i[0] = 1'b1;
    for (int e = 0; e <= 3; e++) tick();
    chk("t031_pre_r",    32'(if0.r_o[0]),  32'd1);
    chk("t031_pre_busy", 32'(if0.busy_o),  32'd1);
    rst_n = 1'b0;
    #1;
    chk("t031_r",    32'(if0.r_o),       32'd0);
    chk("t031_f",    32'(if0.f_o),       32'd0);
    chk("t031_len",  32'(if0.len_o),     32'd0);
    chk("t031_busy", 32'(if0.busy_o),    32'd0);
    chk("t031_vld",  32'(if0.len_vld_o), 32'd0);
    tick();
    chk("t031_vld_b", 32'(if0.len_vld_o), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("t030_r_e0", 32'(if0.r_o[0]), 32'd0);
    tick();
    chk("t030_r_e1", 32'(if0.r_o[0]), 32'd0);
    tick();
    chk("t030_r_e2", 32'(if0.r_o[0]), 32'd1);
    chk("t030_vld",  32'(if0.len_vld_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/edge_track_multi.md
EDGE_TRACK_MULTI -- requirements
Module: edge_track_multi

Interface
REQ-001 Parameter NCH, default 4: number of independent channels, range 1..32.
REQ-002 Parameter FILT, default 2: input debounce length in cycles, range 1..15.
REQ-003 Parameter LAST_LEN, default 1: cycles spent in LAST per fall, range 1..255.
REQ-004 Parameter CNT_W, default 8: run-length counter width, range 2..16.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 do  input  NCH  raw per-channel level, synchronous to clk.
REQ-008 en  input  NCH  per-channel enable; low forces the channel to IDLE.
REQ-009 r  output  NCH  registered; high while the channel is in RUN.
REQ-010 f  output  NCH  registered; high while the channel is in LAST.
REQ-011 len  output  NCH*CNT_W  last completed run length; channel i is in bits [i*CNT_W +: CNT_W].
REQ-012 len_vld  output  NCH  one-cycle pulse when len[i] updates.
REQ-013 busy  output  1  registered OR of all r bits.

Function
REQ-014 Each channel shall run independently; simultaneous events on different channels shall not interact.
REQ-015 Filter: each channel holds a filtered level flt and a mismatch counter mc.
- When do != flt at an edge: if mc == FILT-1, flt <= do and mc <= 0; otherwise mc <= mc+1.
- When do == flt: mc <= 0.
- The filter runs regardless of en.
REQ-016 The per-channel FSM shall have states IDLE, RUN and LAST; nextstate is combinational from state, flt, en and the LAST counter.
REQ-017 IDLE -> RUN when flt=1 and en=1; otherwise the channel stays in IDLE.
REQ-018 RUN -> LAST when flt=0 and en=1; otherwise the channel stays in RUN.
REQ-019 LAST -> RUN when flt=1 and en=1 (retrigger, LAST ends early).
REQ-020 LAST -> IDLE after LAST_LEN cycles in LAST with no retrigger.
REQ-021 Any state -> IDLE on the next edge when en=0; this takes priority over all other transitions.
REQ-022 Illegal state encodings shall go to IDLE on the next edge.
REQ-023 Outputs r and f shall be registered from nextstate, so r/f change on the same edge as state; they shall have no combinational path from inputs.
- Latency: do held high from edge E0 gives flt=1 after E(FILT-1) and r=1 after E(FILT).
REQ-024 Run counter:
- Loads 1 on the edge entering RUN.
- Increments each further cycle in RUN.
- Saturates at 2^CNT_W-1; no wrap.
REQ-025 On RUN->LAST, len[i] shall load the run count (the number of cycles r was high), and len_vld[i] shall pulse for the first f cycle only.
REQ-026 A RUN exit caused by en=0 shall not update len and shall not pulse len_vld.
REQ-027 LAST counter shall clear on entering LAST; f shall be high for exactly LAST_LEN cycles unless the LAST is cut short by retrigger or en=0.

Reset
REQ-028 rst_n low shall immediately force, independent of clk:
- all states to IDLE
- r, f, len_vld, len and busy to 0
- flt, mc and all counters to 0
REQ-029 Reset asserted mid-RUN or mid-LAST shall not pulse len_vld.
REQ-030 After reset deassertion, a channel whose do is already high shall follow REQ-023 timing from the first sampling edge.

Verification
REQ-031 Defaults, rst_n low while ch0 is in RUN -> r=0, f=0, len=0, busy=0 within the same cycle, with no len_vld pulse.
REQ-032 Defaults, ch0 do high for samples E0..E9 then low -> r high E2..E11, f high for 1 cycle at E12, len[0]=10, a single len_vld[0] pulse coincident with f, busy mirrors r.
REQ-033 FILT=2, do[1] high for a single sample -> flt never changes; r, f and len_vld stay 0.
REQ-034 CNT_W=4, ch2 high for 20 cycles -> len[2]=15 (saturated), one len_vld pulse.
REQ-035 LAST_LEN=4, FILT=2, ch3 RUN then do low for 2 samples then high -> f high 2 cycles, then r=1 directly without passing IDLE, len_vld once for the first run.
REQ-036 en[0] dropped mid-RUN while ch1 runs concurrently -> r[0]=0 after the next edge with no len_vld[0]; ch1 outputs unaffected.
